// File: rtl/ser16_tx.sv
// 16-bit parallel-to-serial transmitter with one holding word and 1/2-bit bit requests.
// The output is one continuous bit stream: PAD_BITS zeros, then accepted words MSB first.

module ser16_tx #(
   parameter int PAD_BITS = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic [1:0]  ctrl,
   output logic [1:0]  dataout,
   output logic        word_done,
   output logic        underrun
);

   // Ordered view of everything stored: pad zeros, the front word, then an optional second word.
   typedef struct packed {
      logic [3:0]  pad;
      logic [15:0] a_word;
      logic [4:0]  a_cnt;
      logic        b_valid;
      logic [15:0] b_word;
   } view_t;

   logic [3:0]  pad_cnt;
   logic [15:0] shift_word;
   logic [4:0]  shift_cnt;
   logic [15:0] hold_word;
   logic        hold_valid;

   view_t       view_in;
   view_t       view_one;
   view_t       view_two;
   view_t       view_out;
   logic        bit_first;
   logic        bit_second;
   logic        done_first;
   logic        done_second;
   logic        starve_first;
   logic        starve_second;
   logic [1:0]  dataout_next;
   logic        word_done_next;
   logic        underrun_next;
   logic        accept;

   // Pops one bit from the front of the stream; when the front word runs dry the second word takes its place.
   function automatic view_t take_bit(input view_t v, output logic bit_val,
                                      output logic done, output logic starved);
      view_t r;
      r       = v;
      bit_val = 1'b0;
      done    = 1'b0;
      starved = 1'b0;
      if (r.pad != 4'd0) begin
         r.pad = r.pad - 4'd1;
      end else if (r.a_cnt != 5'd0) begin
         bit_val  = r.a_word[15];
         r.a_word = {r.a_word[14:0], 1'b0};
         r.a_cnt  = r.a_cnt - 5'd1;
         if (r.a_cnt == 5'd0) begin
            done = 1'b1;
            if (r.b_valid) begin
               r.a_word  = r.b_word;
               r.a_cnt   = 5'd16;
               r.b_valid = 1'b0;
            end
         end
      end else begin
         starved = 1'b1;
      end
      return r;
   endfunction

   assign din_ready = ~hold_valid;
   assign accept    = din_valid & din_ready;

   // An empty shift word means the holding word is the front of the stream on this very edge.
   always_comb begin
      view_in.pad = pad_cnt;
      if (shift_cnt != 5'd0) begin
         view_in.a_word  = shift_word;
         view_in.a_cnt   = shift_cnt;
         view_in.b_valid = hold_valid;
         view_in.b_word  = hold_word;
      end else begin
         view_in.a_word  = hold_word;
         view_in.a_cnt   = hold_valid ? 5'd16 : 5'd0;
         view_in.b_valid = 1'b0;
         view_in.b_word  = hold_word;
      end
   end

   always_comb begin
      bit_first     = 1'b0;
      bit_second    = 1'b0;
      done_first    = 1'b0;
      done_second   = 1'b0;
      starve_first  = 1'b0;
      starve_second = 1'b0;
      view_one      = take_bit(view_in, bit_first, done_first, starve_first);
      view_two      = take_bit(view_one, bit_second, done_second, starve_second);
   end

   // Idle requests still let the holding word slide into an empty shift word.
   always_comb begin
      view_out       = view_in;
      dataout_next   = dataout;
      word_done_next = 1'b0;
      underrun_next  = 1'b0;
      case (ctrl)
         2'b01: begin
            view_out       = view_one;
            dataout_next   = {1'b0, bit_first};
            word_done_next = done_first;
            underrun_next  = starve_first;
         end
         2'b11: begin
            view_out       = view_two;
            dataout_next   = {bit_first, bit_second};
            word_done_next = done_first | done_second;
            underrun_next  = starve_first | starve_second;
         end
         default: begin
            view_out = view_in;
         end
      endcase
   end

   // A word accepted here only lands in the holding slot, which is known to be empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_cnt    <= 4'(PAD_BITS);
         shift_word <= 16'h0000;
         shift_cnt  <= 5'd0;
         hold_word  <= 16'h0000;
         hold_valid <= 1'b0;
         dataout    <= 2'b00;
         word_done  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         pad_cnt    <= view_out.pad;
         shift_word <= view_out.a_word;
         shift_cnt  <= view_out.a_cnt;
         hold_word  <= accept ? din : view_out.b_word;
         hold_valid <= accept | view_out.b_valid;
         dataout    <= dataout_next;
         word_done  <= word_done_next;
         underrun   <= underrun_next;
      end
   end

endmodule

// File: tb/tb_ser16_tx.sv
// Bench for ser16_tx: constant vector table, hand-written corner sequences and random traffic
// compared against a bit-queue model of the serial stream.

module tb_ser16_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din;
   logic        din_valid;
   logic [1:0]  ctrl;
   logic        din_ready;
   logic [1:0]  dataout;
   logic        word_done;
   logic        underrun;

   logic [15:0] din3;
   logic        din_valid3;
   logic [1:0]  ctrl3;
   logic        din_ready3;
   logic [1:0]  dataout3;
   logic        word_done3;
   logic        underrun3;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ser16_tx #(.PAD_BITS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .ctrl(ctrl), .dataout(dataout), .word_done(word_done), .underrun(underrun)
   );

   ser16_tx #(.PAD_BITS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .din(din3), .din_valid(din_valid3), .din_ready(din_ready3),
      .ctrl(ctrl3), .dataout(dataout3), .word_done(word_done3), .underrun(underrun3)
   );

   // Reference model: the stream is a queue of bits, each tagged if it is a word's LSB.
   typedef struct packed {
      logic b;
      logic last;
   } sbit_t;

   sbit_t       mq[$];
   logic [1:0]  m_do;
   logic        m_wd;
   logic        m_ur;
   logic        m_rdy;

   typedef struct {
      logic [1:0]  c;
      logic        v;
      logic [15:0] d;
      logic [1:0]  e_do;
      logic        e_wd;
      logic        e_ur;
      logic        e_rdy;
   } vec_t;

   vec_t tbl[$];

   function automatic void addVec(input logic [1:0] c, input logic v, input logic [15:0] d,
                                  input logic [1:0] e_do, input logic e_wd, input logic e_ur,
                                  input logic e_rdy);
      vec_t t;
      t.c = c; t.v = v; t.d = d; t.e_do = e_do; t.e_wd = e_wd; t.e_ur = e_ur; t.e_rdy = e_rdy;
      tbl.push_back(t);
   endfunction

   task automatic modelReset(input int pad);
      sbit_t z;
      mq.delete();
      z.b = 1'b0;
      z.last = 1'b0;
      for (int i = 0; i < pad; i++) mq.push_back(z);
      m_do  = 2'b00;
      m_wd  = 1'b0;
      m_ur  = 1'b0;
      m_rdy = 1'b1;
   endtask

   task automatic modelStep(input logic [1:0] c, input logic v, input logic [15:0] d);
      int    n;
      int    nwords;
      logic  got[2];
      logic  accepted;
      sbit_t s;
      n = (c == 2'b01) ? 1 : (c == 2'b11) ? 2 : 0;
      m_wd = 1'b0;
      m_ur = 1'b0;
      if (n != 0) begin
         for (int i = 0; i < 2; i++) got[i] = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (mq.size() > 0) begin
               s = mq.pop_front();
               got[i] = s.b;
               if (s.last) m_wd = 1'b1;
            end else begin
               m_ur = 1'b1;
            end
         end
         m_do = (n == 1) ? {1'b0, got[0]} : {got[0], got[1]};
      end
      accepted = v && m_rdy;
      if (accepted) begin
         for (int i = 15; i >= 0; i--) begin
            s.b = d[i];
            s.last = (i == 0);
            mq.push_back(s);
         end
      end
      nwords = 0;
      foreach (mq[i]) if (mq[i].last) nwords++;
      m_rdy = !((nwords >= 2) || (nwords == 1 && accepted));
   endtask

   task automatic checkOutput(input string name, input logic [1:0] got_do, input logic [1:0] exp_do,
                              input logic got_wd, input logic exp_wd, input logic got_ur,
                              input logic exp_ur, input logic got_rdy, input logic exp_rdy);
      vectors++;
      if ({got_do, got_wd, got_ur, got_rdy} !== {exp_do, exp_wd, exp_ur, exp_rdy}) begin
         miscompares++;
         $display("[TB] FAIL %s: got dataout=%b word_done=%b underrun=%b din_ready=%b, expected dataout=%b word_done=%b underrun=%b din_ready=%b",
                  name, got_do, got_wd, got_ur, got_rdy, exp_do, exp_wd, exp_ur, exp_rdy);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, dataout, m_do, word_done, m_wd, underrun, m_ur, din_ready, m_rdy);
   endtask

   task automatic applyStimulus(input logic [1:0] c, input logic v, input logic [15:0] d);
      ctrl      = c;
      din_valid = v;
      din       = d;
      modelStep(c, v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      ctrl = 2'b00; din_valid = 1'b0; din = 16'h0000;
      ctrl3 = 2'b00; din_valid3 = 1'b0; din3 = 16'h0000;
      modelReset(0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] pat;
      logic [2:0]  r;
      logic [1:0]  rc;

      rst_n = 1'b0;
      ctrl = 2'b00; din_valid = 1'b0; din = 16'h0000;
      ctrl3 = 2'b00; din_valid3 = 1'b0; din3 = 16'h0000;
      modelReset(0);
      #3;
      checkOutput("reset0", dataout, 2'b00, word_done, 1'b0, underrun, 1'b0, din_ready, 1'b1);
      checkOutput("reset3", dataout3, 2'b00, word_done3, 1'b0, underrun3, 1'b0, din_ready3, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Constant vectors: A5C3 in 1-bit mode, then again in 2-bit mode, idle hold and underrun.
      pat = 16'b1010_0101_1100_0011;
      addVec(2'b00, 1'b1, 16'hA5C3, 2'b00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         addVec(2'b01, 1'b0, 16'h0000, {1'b0, pat[15-i]}, (i == 15), 1'b0, 1'b1);
      addVec(2'b00, 1'b1, 16'hA5C3, 2'b01, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
         addVec(2'b11, 1'b0, 16'h0000, {pat[15-2*i], pat[14-2*i]}, (i == 7), 1'b0, 1'b1);
      addVec(2'b10, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1);
      addVec(2'b01, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1);
      addVec(2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);

      foreach (tbl[i]) begin
         applyStimulus(tbl[i].c, tbl[i].v, tbl[i].d);
         checkOutput($sformatf("tbl[%0d]", i), dataout, tbl[i].e_do, word_done, tbl[i].e_wd,
                     underrun, tbl[i].e_ur, din_ready, tbl[i].e_rdy);
      end

      // Straddle: FFFF with one bit taken, then 0000 behind it, drained in 2-bit mode.
      doReset();
      applyStimulus(2'b00, 1'b1, 16'hFFFF);
      checkModel("strad_acc1");
      applyStimulus(2'b00, 1'b0, 16'h0000);
      checkModel("strad_move");
      applyStimulus(2'b01, 1'b1, 16'h0000);
      checkOutput("strad_first", dataout, 2'b01, word_done, 1'b0, underrun, 1'b0, din_ready, 1'b0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2'b11, 1'b0, 16'h0000);
         if (i == 7)
            checkOutput("strad_edge8", dataout, 2'b10, word_done, 1'b1, underrun, 1'b0, din_ready, 1'b1);
         else if (i == 8)
            checkOutput("strad_edge9", dataout, 2'b00, word_done, 1'b0, underrun, 1'b0, din_ready, 1'b1);
         else if (i == 15)
            checkOutput("strad_edge16", dataout, 2'b00, word_done, 1'b1, underrun, 1'b1, din_ready, 1'b1);
         else
            checkModel($sformatf("strad_%0d", i));
      end

      // Underrun with nothing stored, then one word drained by 17 single-bit requests.
      doReset();
      applyStimulus(2'b11, 1'b0, 16'h0000);
      checkOutput("ur_empty", dataout, 2'b00, word_done, 1'b0, underrun, 1'b1, din_ready, 1'b1);
      applyStimulus(2'b00, 1'b0, 16'h0000);
      checkOutput("ur_clear", dataout, 2'b00, word_done, 1'b0, underrun, 1'b0, din_ready, 1'b1);
      applyStimulus(2'b00, 1'b1, 16'h8001);
      checkModel("ur_acc");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(2'b01, 1'b0, 16'h0000);
         if (i == 15)
            checkOutput("ur_done16", dataout, 2'b01, word_done, 1'b1, underrun, 1'b0, din_ready, 1'b1);
         else if (i == 16)
            checkOutput("ur_edge17", dataout, 2'b00, word_done, 1'b0, underrun, 1'b1, din_ready, 1'b1);
         else
            checkModel($sformatf("ur_%0d", i));
      end

      // Backpressure: with both slots full a third offered word must be refused.
      doReset();
      applyStimulus(2'b00, 1'b1, 16'h1234);
      applyStimulus(2'b00, 1'b0, 16'h0000);
      checkModel("bp_move");
      applyStimulus(2'b00, 1'b1, 16'hABCD);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b00, 1'b1, 16'hDEAD);
         checkOutput($sformatf("bp_full_%0d", i), dataout, 2'b00, word_done, 1'b0, underrun, 1'b0,
                     din_ready, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2'b11, 1'b0, 16'h0000);
         checkModel($sformatf("bp_drain_%0d", i));
      end
      applyStimulus(2'b11, 1'b0, 16'h0000);
      checkOutput("bp_no_third", dataout, 2'b00, word_done, 1'b0, underrun, 1'b1, din_ready, 1'b1);

      // PAD_BITS=3 instance: pad zeros come first, then an asynchronous reset mid-word.
      doReset();
      din3 = 16'hFFFF; din_valid3 = 1'b1; ctrl3 = 2'b00;
      applyStimulus(2'b00, 1'b0, 16'h0000);
      checkOutput("pad_acc", dataout3, 2'b00, word_done3, 1'b0, underrun3, 1'b0, din_ready3, 1'b0);
      din_valid3 = 1'b0; ctrl3 = 2'b01;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'b00, 1'b0, 16'h0000);
         checkOutput($sformatf("pad_bit_%0d", i), dataout3, {1'b0, (i >= 3)}, word_done3, 1'b0,
                     underrun3, 1'b0, din_ready3, 1'b1);
      end
      ctrl3 = 2'b00;
      applyStimulus(2'b01, 1'b1, 16'hF00F);
      applyStimulus(2'b01, 1'b0, 16'h0000);
      rst_n = 1'b0;
      modelReset(0);
      #1;
      checkOutput("rst_async3", dataout3, 2'b00, word_done3, 1'b0, underrun3, 1'b0, din_ready3, 1'b1);
      checkOutput("rst_async0", dataout, 2'b00, word_done, 1'b0, underrun, 1'b0, din_ready, 1'b1);
      ctrl = 2'b00; din_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      din3 = 16'hFFFF; din_valid3 = 1'b1; ctrl3 = 2'b00;
      applyStimulus(2'b00, 1'b0, 16'h0000);
      din_valid3 = 1'b0; ctrl3 = 2'b11;
      applyStimulus(2'b00, 1'b0, 16'h0000);
      checkOutput("post_pad_a", dataout3, 2'b00, word_done3, 1'b0, underrun3, 1'b0, din_ready3, 1'b1);
      applyStimulus(2'b00, 1'b0, 16'h0000);
      checkOutput("post_pad_b", dataout3, 2'b01, word_done3, 1'b0, underrun3, 1'b0, din_ready3, 1'b1);
      ctrl3 = 2'b01;
      applyStimulus(2'b00, 1'b0, 16'h0000);
      checkOutput("post_pad_c", dataout3, 2'b01, word_done3, 1'b0, underrun3, 1'b0, din_ready3, 1'b1);
      ctrl3 = 2'b00;
      checkModel("post_rst0");

      // Random traffic against the model.
      doReset();
      for (int i = 0; i < 800; i++) begin
         r = 3'($urandom_range(0, 7));
         case (r)
            3'd0, 3'd1, 3'd2: rc = 2'b00;
            3'd3:             rc = 2'b10;
            3'd4, 3'd5:       rc = 2'b01;
            default:          rc = 2'b11;
         endcase
         applyStimulus(rc, 1'($urandom_range(0, 1)), 16'($urandom));
         checkModel($sformatf("rand_%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
